// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the hex display arbiter.
// - FSM state encoding (IDLE, HOLD, OPEN)
// - Display geometry: 32-bit value, eight hex digits
// - wrap_inc: modular add used for round-robin pointer arithmetic
package hex_display_arbiter_pkg;

   localparam int DISP_W  = 32;
   localparam int DIGITS  = 8;
   localparam int IDX_W   = 3;             // owner/pointer width, covers up to 8 requesters
   localparam int MAX_REQ = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      OPEN = 2'd2
   } state_t;

   // (base + step) mod n, with base < n and step < n assumed
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                 input int unsigned step,
                                                 input int unsigned n);
      int unsigned s;
      s = 32'(base) + step;
      if (s >= n) s = s - n;
      return IDX_W'(s);
   endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   mask  - candidate requesters
//   ptr   - highest-priority position for this scan
//   found - at least one candidate set
//   index - first set bit scanning ptr, ptr+1, ... mod N_REQ
module hex_display_arbiter_rr_picker
   import hex_display_arbiter_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   // Padded so any 3-bit position indexes it cleanly
   logic [MAX_REQ-1:0] mask_pad;
   assign mask_pad = MAX_REQ'(mask);

   // Walk from the farthest position back to ptr so the nearest hit wins
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (mask_pad[wrap_inc(ptr, k, N_REQ)]) begin
            found = 1'b1;
            index = wrap_inc(ptr, k, N_REQ);
         end
      end
   end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the 8-digit hex display among N_REQ producers.
// Each grant is held for at least HOLD_TICKS tick strobes so the shown value
// stays readable; afterwards a waiting requester takes over with no idle gap.
// Ports:
//   clock, reset(active-low async) - timing/reset
//   tick  - one-cycle hold-time strobe
//   req   - per-requester level request
//   data  - requester i value at [32*i+31:32*i]
//   grant - one-hot owner or zero; owner - current/last owner index
//   valid - display shows a granted value; value - word to the decoders
module hex_display_arbiter
   import hex_display_arbiter_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int HOLD_TICKS = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [N_REQ-1:0]        req,
   input  logic [DISP_W*N_REQ-1:0] data,
   output logic [N_REQ-1:0]        grant,
   output logic [IDX_W-1:0]        owner,
   output logic                    valid,
   output logic [DISP_W-1:0]       value
);

   localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

   state_t             state, state_nxt;
   logic [7:0]         hold_cnt, hold_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_nxt, owner_nxt;
   logic [N_REQ-1:0]   grant_nxt;
   logic               valid_nxt;
   logic [DISP_W-1:0]  value_nxt;

   logic [DISP_W-1:0]  words [MAX_REQ];
   logic [MAX_REQ-1:0] req_pad;
   logic [N_REQ-1:0]   cand;
   logic [IDX_W-1:0]   pick_ptr, pick, owner_inc;
   logic               found;
   logic [MAX_REQ-1:0] pick_oh;
   logic               take;

   // Per-requester words, padded to 8 entries so a 3-bit index is always legal
   genvar gi;
   generate
      for (gi = 0; gi < MAX_REQ; gi++) begin : g_words
         if (gi < N_REQ) begin : g_live
            assign words[gi] = data[DISP_W*gi +: DISP_W];
         end else begin : g_pad
            assign words[gi] = '0;
         end
      end
   endgenerate

   assign req_pad   = MAX_REQ'(req);
   assign owner_inc = wrap_inc(owner, 1, N_REQ);

   // From IDLE anyone may win starting at rr_ptr; while owned only the
   // other requesters compete, starting just after the current owner.
   assign cand     = (state == IDLE) ? req : (req & ~grant);
   assign pick_ptr = (state == IDLE) ? rr_ptr : owner_inc;

   hex_display_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .mask  (cand),
      .ptr   (pick_ptr),
      .found (found),
      .index (pick)
   );

   assign pick_oh = MAX_REQ'(1) << pick;

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      rr_nxt    = rr_ptr;
      owner_nxt = owner;
      grant_nxt = grant;
      valid_nxt = valid;
      value_nxt = value;
      take      = 1'b0;

      case (state)
         IDLE: begin
            take = found;
         end
         HOLD, OPEN: begin
            // Live value while the owner keeps requesting, frozen otherwise
            if (req_pad[owner]) value_nxt = words[owner];

            if (state == HOLD && hold_cnt != 8'd0) begin
               if (tick) hold_nxt = hold_cnt - 8'd1;
            end else if (found) begin
               // Switch beats release: no idle cycle between owners
               take   = 1'b1;
               rr_nxt = owner_inc;
            end else if (!req_pad[owner]) begin
               // Release: value stays on the display, owner index kept
               state_nxt = IDLE;
               grant_nxt = '0;
               valid_nxt = 1'b0;
               rr_nxt    = owner_inc;
            end else begin
               state_nxt = OPEN;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (take) begin
         state_nxt = HOLD;
         grant_nxt = pick_oh[N_REQ-1:0];
         owner_nxt = pick;
         valid_nxt = 1'b1;
         value_nxt = words[pick];
         hold_nxt  = HOLD_INIT;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
         rr_ptr   <= '0;
         owner    <= '0;
         grant    <= '0;
         valid    <= 1'b0;
         value    <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rr_ptr   <= rr_nxt;
         owner    <= owner_nxt;
         grant    <= grant_nxt;
         valid    <= valid_nxt;
         value    <= value_nxt;
      end
   end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter (N_REQ=4, HOLD_TICKS=3, tick always 1).
// Per-cycle vectors live in a table; async-reset, release and OPEN-state
// corners are written out as short sequences.
module tb_hex_display_arbiter;

   localparam int N_REQ = 4;
   localparam int HOLD_TICKS = 3;

   localparam logic [31:0] D0 = 32'hAAAA_0000;
   localparam logic [31:0] D1 = 32'hBBBB_1111;
   localparam logic [31:0] D2 = 32'hCCCC_2222;
   localparam logic [31:0] D3 = 32'hDDDD_3333;
   localparam logic [127:0] DATA = {D3, D2, D1, D0};

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          tick  = 1'b1;
   logic [3:0]    req   = '0;
   logic [127:0]  data  = '0;
   logic [3:0]    grant;
   logic [2:0]    owner;
   logic          valid;
   logic [31:0]   value;

   int n_checks = 0;
   int n_fail   = 0;

   hex_display_arbiter #(.N_REQ(N_REQ), .HOLD_TICKS(HOLD_TICKS)) dut (
      .clock (clock),
      .reset (reset),
      .tick  (tick),
      .req   (req),
      .data  (data),
      .grant (grant),
      .owner (owner),
      .valid (valid),
      .value (value)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic         rst;     // pulse reset before applying this vector
      logic [3:0]   req;
      logic [127:0] data;
      logic [3:0]   grant;
      logic [2:0]   owner;
      logic         valid;
      logic [31:0]  value;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] r, input logic [127:0] d,
                      input logic [3:0] g, input logic [2:0] o, input logic v,
                      input logic [31:0] val);
      vec_t x;
      x.rst = rst; x.req = r; x.data = d;
      x.grant = g; x.owner = o; x.valid = v; x.value = val;
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input logic [3:0] eg, input logic [2:0] eo,
                        input logic ev, input logic [31:0] evl);
      n_checks++;
      if (grant !== eg || owner !== eo || valid !== ev || value !== evl) begin
         n_fail++;
         $display("FAIL %s: got grant=%b owner=%0d valid=%b value=%h, want grant=%b owner=%0d valid=%b value=%h",
                  name, grant, owner, valid, value, eg, eo, ev, evl);
      end
   endtask

   // Leaves us 1 ns after a rising edge with reset released
   task automatic do_reset();
      reset = 1'b0;
      req   = '0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] dw [4];
      dw[0] = D0; dw[1] = D1; dw[2] = D2; dw[3] = D3;

      // Grant after one cycle, value follows owner's data while held
      add(1, 4'b0001, {D3, D2, D1, 32'h1234_5678}, 4'b0001, 0, 1, 32'h1234_5678);
      add(0, 4'b0001, {D3, D2, D1, 32'hA5A5_A5A5}, 4'b0001, 0, 1, 32'hA5A5_A5A5);
      add(0, 4'b0001, {D3, D2, D1, 32'h0BAD_F00D}, 4'b0001, 0, 1, 32'h0BAD_F00D);

      // Second requester waits out the hold, then takes over with no valid gap
      add(1, 4'b0001, DATA, 4'b0001, 0, 1, D0);
      add(0, 4'b0101, DATA, 4'b0001, 0, 1, D0);
      add(0, 4'b0101, DATA, 4'b0001, 0, 1, D0);
      add(0, 4'b0101, DATA, 4'b0001, 0, 1, D0);
      add(0, 4'b0101, DATA, 4'b0100, 2, 1, D2);
      add(0, 4'b0101, DATA, 4'b0100, 2, 1, D2);

      // All requesting: rotate 0,1,2,3,0 with 4 cycles per grant
      for (int i = 0; i < 17; i++) begin
         int o;
         o = (i / 4) % 4;
         add(i == 0, 4'b1111, DATA, 4'b0001 << o, 3'(o), 1, dw[o]);
      end

      // Reset state, no clock edge yet
      reset = 1'b0;
      #2;
      check("reset_state", 4'b0000, 0, 0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         req  = vecs[i].req;
         data = vecs[i].data;
         step();
         check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].valid, vecs[i].value);
      end

      // Owner drops early: frozen value through expiry, release, then wrap pick
      do_reset();
      req = 4'b0010; data = DATA;
      step();
      check("drop_grant", 4'b0010, 1, 1, D1);
      req = 4'b0000; data = {D3, D2, 32'hDEAD_BEEF, D0};
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("drop_hold%0d", i), 4'b0010, 1, 1, D1);
      end
      step();
      check("drop_release", 4'b0000, 1, 0, D1);
      step();
      check("idle_keeps", 4'b0000, 1, 0, D1);
      req = 4'b0011; data = DATA;
      step();
      check("wrap_pick", 4'b0001, 0, 1, D0);

      // OPEN: value tracks owner, newcomer switches at the next edge
      do_reset();
      req = 4'b0001; data = DATA;
      for (int i = 0; i < 5; i++) step();
      check("open_hold", 4'b0001, 0, 1, D0);
      data = {D3, D2, D1, 32'h55AA_55AA};
      step();
      check("open_track", 4'b0001, 0, 1, 32'h55AA_55AA);
      req = 4'b1001; data = DATA;
      step();
      check("open_switch", 4'b1000, 3, 1, D3);
      step();
      check("switch_holds", 4'b1000, 3, 1, D3);

      // Asynchronous reset mid-hold, then pointer restarts at 0
      do_reset();
      req = 4'b0100; data = DATA;
      step();
      check("pre_async", 4'b0100, 2, 1, D2);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", 4'b0000, 0, 0, 32'h0);
      reset = 1'b1;
      req = 4'b0010;
      step();
      check("post_reset", 4'b0010, 1, 1, D1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
